// File: rtl/alarm_pkg.sv
// Shared types for the alarm controller: FSM state, BCD time word and the
// load-validity rule for a 24-hour HH:MM alarm.
package alarm_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ARMED  = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } alarm_state_t;

    typedef struct packed {
        logic [3:0] hourdec;
        logic [3:0] hourone;
        logic [3:0] mindec;
        logic [3:0] minone;
    } bcd_time_t;

    localparam int         CNT_W   = 4;
    localparam logic [3:0] CNT_MAX = 4'hF;

    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic ok;
        ok = (t.hourdec <= 4'd2) && (t.hourone <= 4'd9) &&
             (t.mindec  <= 4'd5) && (t.minone  <= 4'd9);
        // Hours 24..29 are not a time of day.
        if ((t.hourdec == 4'd2) && (t.hourone > 4'd3))
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/alarm_minute_tick.sv
// Minute tick from the watch counter: one cycle high whenever the minute-ones
// digit differs from the value seen on the previous clock.
module alarm_minute_tick (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] minone_now,
    output logic       minute_tick
);

    logic [3:0] minone_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            minone_q <= 4'd0;
        else
            minone_q <= minone_now;
    end

    assign minute_tick = (minone_now != minone_q);

endmodule

// File: rtl/alarm_match_ctrl.sv
// Alarm controller: stores a validated alarm time, detects the rising edge of
// time==alarm, and runs OFF/ARMED/RING/SNOOZE with minute-based timeouts.
module alarm_match_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] hourdec_now,
    input  logic [3:0] hourone_now,
    input  logic [3:0] mindec_now,
    input  logic [3:0] minone_now,
    input  logic       alarm_load,
    input  logic [3:0] alarm_hourdec_in,
    input  logic [3:0] alarm_hourone_in,
    input  logic [3:0] alarm_mindec_in,
    input  logic [3:0] alarm_minone_in,
    input  logic       arm_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic [3:0] alarm_hourdec,
    output logic [3:0] alarm_hourone,
    output logic [3:0] alarm_mindec,
    output logic [3:0] alarm_minone,
    output logic       sound_en,
    output logic       snoozing,
    output logic       load_err
);

    localparam logic [CNT_W-1:0] SNOOZE_INIT = CNT_W'(SNOOZE_MIN);
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_MIN - 1);

    alarm_state_t      state_q, state_d;
    logic [CNT_W-1:0]  ring_cnt_q, ring_cnt_d;
    logic [CNT_W-1:0]  snooze_cnt_q, snooze_cnt_d;
    logic              sound_en_q, sound_en_d;
    logic              snoozing_q, snoozing_d;
    bcd_time_t         alarm_q, alarm_in, now;
    logic              load_err_q;
    logic              match, match_q, match_edge;
    logic              minute_tick;

    assign now      = '{hourdec: hourdec_now, hourone: hourone_now,
                        mindec: mindec_now, minone: minone_now};
    assign alarm_in = '{hourdec: alarm_hourdec_in, hourone: alarm_hourone_in,
                        mindec: alarm_mindec_in, minone: alarm_minone_in};

    assign match      = (now == alarm_q);
    assign match_edge = match & ~match_q;

    alarm_minute_tick u_tick (
        .clk         (clk),
        .rstn        (rstn),
        .minone_now  (minone_now),
        .minute_tick (minute_tick)
    );

    // Alarm storage and match history run independently of the FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alarm_q    <= '0;
            load_err_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            match_q    <= match;
            load_err_q <= alarm_load & ~bcd_time_valid(alarm_in);
            if (alarm_load && bcd_time_valid(alarm_in))
                alarm_q <= alarm_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= OFF;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            sound_en_q   <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            sound_en_q   <= sound_en_d;
            snoozing_q   <= snoozing_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        if (!arm_en) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF:   state_d = ARMED;
                ARMED: begin
                    if (match_edge) begin
                        state_d    = RING;
                        ring_cnt_d = '0;
                    end
                end
                RING: begin
                    if (stop_btn) begin
                        state_d = ARMED;
                    end else if (snooze_btn) begin
                        state_d      = SNOOZE;
                        snooze_cnt_d = SNOOZE_INIT;
                    end else if (minute_tick) begin
                        if (ring_cnt_q == RING_LAST)
                            state_d = ARMED;
                        else if (ring_cnt_q != CNT_MAX)
                            ring_cnt_d = ring_cnt_q + 1'b1;
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_d = ARMED;
                    end else if (minute_tick) begin
                        if (snooze_cnt_q == 4'd1) begin
                            state_d      = RING;
                            ring_cnt_d   = '0;
                            snooze_cnt_d = '0;
                        end else if (snooze_cnt_q != '0) begin
                            snooze_cnt_d = snooze_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Outputs decode the next state so the registered copies track state_q.
    always_comb begin
        sound_en_d = (state_d == RING);
        snoozing_d = (state_d == SNOOZE);
    end

    assign sound_en      = sound_en_q;
    assign snoozing      = snoozing_q;
    assign load_err      = load_err_q;
    assign alarm_hourdec = alarm_q.hourdec;
    assign alarm_hourone = alarm_q.hourone;
    assign alarm_mindec  = alarm_q.mindec;
    assign alarm_minone  = alarm_q.minone;

endmodule

// File: tb/tb_alarm_match_ctrl.sv
// Bench for alarm_match_ctrl: directed scenarios with literal expectations,
// then random stimulus, all cross-checked every cycle against a minute-level model.
module tb_alarm_match_ctrl;

    localparam int SNOOZE_MIN = 5;
    localparam int RING_MIN   = 2;
    localparam int M_OFF = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] hourdec_now = '0, hourone_now = '0, mindec_now = '0, minone_now = '0;
    logic       alarm_load = 1'b0;
    logic [3:0] alarm_hourdec_in = '0, alarm_hourone_in = '0;
    logic [3:0] alarm_mindec_in = '0, alarm_minone_in = '0;
    logic       arm_en = 1'b0, snooze_btn = 1'b0, stop_btn = 1'b0;
    logic [3:0] alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone;
    logic       sound_en, snoozing, load_err;

    int errors = 0;
    int checks = 0;

    alarm_match_ctrl #(.SNOOZE_MIN(SNOOZE_MIN), .RING_MIN(RING_MIN)) dut (
        .clk(clk), .rstn(rstn),
        .hourdec_now(hourdec_now), .hourone_now(hourone_now),
        .mindec_now(mindec_now), .minone_now(minone_now),
        .alarm_load(alarm_load),
        .alarm_hourdec_in(alarm_hourdec_in), .alarm_hourone_in(alarm_hourone_in),
        .alarm_mindec_in(alarm_mindec_in), .alarm_minone_in(alarm_minone_in),
        .arm_en(arm_en), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .alarm_hourdec(alarm_hourdec), .alarm_hourone(alarm_hourone),
        .alarm_mindec(alarm_mindec), .alarm_minone(alarm_minone),
        .sound_en(sound_en), .snoozing(snoozing), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time as minutes of day, state as a small integer, counters as
    // minutes rung / minutes of snooze remaining.
    int m_st = M_OFF, m_rung = 0, m_snz_left = 0, m_prev_min = 0, m_err = 0;
    int m_alarm_min = 0;
    bit m_prev_match = 0;

    function automatic int now_minutes();
        return (int'(hourdec_now) * 10 + int'(hourone_now)) * 60 +
               int'(mindec_now) * 10 + int'(minone_now);
    endfunction

    function automatic int alarm_word(input int m);
        return ((m / 600) << 12) | (((m / 60) % 10) << 8) | (((m % 60) / 10) << 4) | (m % 10);
    endfunction

    task automatic model_step();
        int  nst, hh, mm, ld_h, ld_m;
        bit  match, edge_s, tick;
        if (!rstn) begin
            m_st = M_OFF; m_rung = 0; m_snz_left = 0; m_prev_min = 0;
            m_err = 0; m_alarm_min = 0; m_prev_match = 0;
            return;
        end
        // digits must each be in range for the minute count to be meaningful
        match  = (hourdec_now <= 2) && (hourone_now <= 9) && (mindec_now <= 5) &&
                 (minone_now <= 9) && (now_minutes() == m_alarm_min);
        edge_s = match && !m_prev_match;
        tick   = int'(minone_now) != m_prev_min;
        nst    = m_st;
        if (!arm_en) nst = M_OFF;
        else if (m_st == M_OFF) nst = M_ARMED;
        else if (m_st == M_ARMED) begin
            if (edge_s) begin nst = M_RING; m_rung = 0; end
        end else if (m_st == M_RING) begin
            if (stop_btn) nst = M_ARMED;
            else if (snooze_btn) begin nst = M_SNOOZE; m_snz_left = SNOOZE_MIN; end
            else if (tick) begin
                m_rung++;
                if (m_rung >= RING_MIN) nst = M_ARMED;
            end
        end else begin
            if (stop_btn) nst = M_ARMED;
            else if (tick) begin
                m_snz_left--;
                if (m_snz_left == 0) begin nst = M_RING; m_rung = 0; end
            end
        end
        ld_h = int'(alarm_hourdec_in) * 10 + int'(alarm_hourone_in);
        ld_m = int'(alarm_mindec_in) * 10 + int'(alarm_minone_in);
        hh = ld_h; mm = ld_m;
        m_err = 0;
        if (alarm_load) begin
            if (alarm_hourdec_in <= 2 && alarm_hourone_in <= 9 && hh <= 23 &&
                alarm_mindec_in <= 5 && alarm_minone_in <= 9)
                m_alarm_min = hh * 60 + mm;
            else
                m_err = 1;
        end
        m_prev_match = match;
        m_prev_min   = int'(minone_now);
        m_st         = nst;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("cmp_sound_en", int'(sound_en), int'(m_st == M_RING));
            chk("cmp_snoozing", int'(snoozing), int'(m_st == M_SNOOZE));
            chk("cmp_load_err", int'(load_err), m_err);
            chk("cmp_alarm", int'({alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone}),
                alarm_word(m_alarm_min));
        end
    end

    task automatic set_time(input int m);
        hourdec_now = 4'((m / 60) / 10);
        hourone_now = 4'((m / 60) % 10);
        mindec_now  = 4'((m % 60) / 10);
        minone_now  = 4'(m % 10);
    endtask

    task automatic step_time(input int m);
        set_time(m);
        @(negedge clk);
    endtask

    task automatic do_load(input int hd, input int ho, input int md, input int mo);
        alarm_load = 1'b1;
        alarm_hourdec_in = 4'(hd); alarm_hourone_in = 4'(ho);
        alarm_mindec_in  = 4'(md); alarm_minone_in  = 4'(mo);
        @(negedge clk);
        alarm_load = 1'b0;
    endtask

    function automatic int shown_alarm();
        return int'({alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone});
    endfunction

    initial begin
        int tmin, r;
        repeat (2) @(negedge clk);
        chk("reset_sound", int'(sound_en), 0);
        chk("reset_snooze", int'(snoozing), 0);
        chk("reset_load_err", int'(load_err), 0);
        chk("reset_alarm", shown_alarm(), 16'h0000);
        rstn = 1'b1;
        @(negedge clk);

        // Ring at 07:30, auto-stop after two minute ticks
        arm_en = 1'b1;
        set_time(7 * 60 + 29);
        do_load(0, 7, 3, 0);
        chk("load_0730", shown_alarm(), 16'h0730);
        @(negedge clk);
        step_time(7 * 60 + 30);
        chk("ring_start", int'(sound_en), 1);
        step_time(7 * 60 + 31);
        chk("ring_tick1", int'(sound_en), 1);
        step_time(7 * 60 + 32);
        chk("ring_autostop", int'(sound_en), 0);

        // Snooze for five ticks, then stop
        step_time(7 * 60 + 29);
        step_time(7 * 60 + 30);
        chk("ring_again", int'(sound_en), 1);
        snooze_btn = 1'b1; @(negedge clk); snooze_btn = 1'b0;
        chk("snooze_on", int'(snoozing), 1);
        for (int i = 1; i <= 5; i++) begin
            step_time(7 * 60 + 30 + i);
            if (i < 5) chk("snooze_hold", int'(snoozing), 1);
        end
        chk("snooze_rering", int'(sound_en), 1);
        stop_btn = 1'b1; @(negedge clk); stop_btn = 1'b0;
        chk("stop_sound", int'(sound_en), 0);
        chk("stop_snooze", int'(snoozing), 0);

        // Rejected and accepted loads
        do_load(2, 4, 0, 0);
        chk("err_2400", int'(load_err), 1);
        chk("keep_2400", shown_alarm(), 16'h0730);
        @(negedge clk);
        chk("err_pulse_end", int'(load_err), 0);
        do_load(0, 9, 6, 0);
        chk("err_0960", int'(load_err), 1);
        chk("keep_0960", shown_alarm(), 16'h0730);
        do_load(2, 3, 5, 9);
        chk("ok_2359_err", int'(load_err), 0);
        chk("ok_2359", shown_alarm(), 16'h2359);

        // Stop and snooze together: stop wins
        step_time(23 * 60 + 58);
        step_time(23 * 60 + 59);
        chk("ring_2359", int'(sound_en), 1);
        stop_btn = 1'b1; snooze_btn = 1'b1; @(negedge clk);
        stop_btn = 1'b0; snooze_btn = 1'b0;
        chk("both_sound", int'(sound_en), 0);
        chk("both_snooze", int'(snoozing), 0);

        // Disarm during snooze
        step_time(23 * 60 + 58);
        step_time(23 * 60 + 59);
        snooze_btn = 1'b1; @(negedge clk); snooze_btn = 1'b0;
        chk("snooze2_on", int'(snoozing), 1);
        arm_en = 1'b0; @(negedge clk);
        chk("disarm_snooze", int'(snoozing), 0);
        for (int i = 0; i < 8; i++) begin
            step_time(i);
            chk("disarm_silent", int'(sound_en), 0);
        end

        // Arming while already matching does not ring
        set_time(12 * 60);
        do_load(1, 2, 0, 0);
        arm_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("arm_on_match", int'(sound_en), 0);

        // Day wrap to alarm 00:00
        do_load(0, 0, 0, 0);
        step_time(23 * 60 + 59);
        step_time(0);
        chk("daywrap_ring", int'(sound_en), 1);
        stop_btn = 1'b1; @(negedge clk); stop_btn = 1'b0;

        // Asynchronous reset mid-ring
        do_load(0, 7, 3, 0);
        step_time(7 * 60 + 29);
        step_time(7 * 60 + 30);
        chk("ring_pre_reset", int'(sound_en), 1);
        #2 rstn = 1'b0;
        #1 chk("async_reset_sound", int'(sound_en), 0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        chk("reset_alarm_0000", shown_alarm(), 16'h0000);
        chk("reset_off", int'(sound_en), 0);

        // Random phase, steered toward alarm matches
        tmin = 7 * 60 + 30;
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 20) tmin = (tmin + 1) % 1440;
            else if (r < 23) tmin = (m_alarm_min + 1439) % 1440;
            else if (r < 24) tmin = int'($urandom_range(0, 1439));
            set_time(tmin);
            snooze_btn = ($urandom_range(0, 24) == 0);
            stop_btn   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 99) == 0) arm_en = ~arm_en;
            if ($urandom_range(0, 1) == 0 && !arm_en) arm_en = ($urandom_range(0, 9) == 0);
            rstn = ($urandom_range(0, 599) != 0);
            alarm_load = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 0) begin
                r = int'($urandom_range(0, 1439));
                alarm_hourdec_in = 4'((r / 60) / 10); alarm_hourone_in = 4'((r / 60) % 10);
                alarm_mindec_in  = 4'((r % 60) / 10); alarm_minone_in  = 4'(r % 10);
            end else begin
                alarm_hourdec_in = 4'($urandom_range(0, 15));
                alarm_hourone_in = 4'($urandom_range(0, 15));
                alarm_mindec_in  = 4'($urandom_range(0, 15));
                alarm_minone_in  = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        rstn = 1'b1; alarm_load = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_match_ctrl.md
# alarm_match_ctrl

Downstream consumer of the BCD watch counter: it takes the current time (`hourdec_now`, `hourone_now`, `mindec_now`, `minone_now`), holds a user-loaded alarm time, and runs the alarm state machine. On a match it asserts `sound_en` toward the sound generator and supports stop, snooze and automatic ring timeout. All timing is counted in minutes, taken from changes of `minone_now`.

## Interface
Parameters:
- `SNOOZE_MIN`, default 5: snooze length in minute ticks, range 1..15.
- `RING_MIN`, default 2: ring duration before auto-stop, in minute ticks, range 1..15.

Ports:
- `clk`  in  1  system clock. Only clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `hourdec_now`, `hourone_now`, `mindec_now`, `minone_now`  in  4 each  current BCD time from the watch counter.
- `alarm_load`  in  1  one-cycle pulse. Loads the `alarm_*_in` values.
- `alarm_hourdec_in`, `alarm_hourone_in`, `alarm_mindec_in`, `alarm_minone_in`  in  4 each  alarm time to load.
- `arm_en`  in  1  level signal. Alarm enable switch.
- `snooze_btn`  in  1  one-cycle pulse. Already debounced.
- `stop_btn`  in  1  one-cycle pulse. Already debounced.
- `alarm_hourdec`, `alarm_hourone`, `alarm_mindec`, `alarm_minone`  out  4 each  stored alarm time, for display.
- `sound_en`  out  1  high in RING.
- `snoozing`  out  1  high in SNOOZE.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset:
  - Stored alarm = 00:00.
  - State = OFF.
  - `sound_en`, `snoozing`, `load_err` = 0.
  - `minone_q` = 0, `match_q` = 0.
  - Snooze and ring counters = 0.
- Load validity: a load is valid only if all of the following hold:
  - `hourdec_in` ≤ 2;
  - `hourone_in` ≤ 9, and ≤ 3 when `hourdec_in` = 2;
  - `mindec_in` ≤ 5;
  - `minone_in` ≤ 9.
- Load result:
  - Valid load: all four stored registers update together.
  - Invalid load: the stored registers are unchanged and `load_err` pulses.
  - A load is accepted in every state and does not change the state.
- `match` (combinational): all four `_now` digits equal the stored digits.
- `match_edge` = `match & ~match_q`.
- `minute_tick` = (`minone_now` != `minone_q`).
- States: OFF, ARMED, RING, SNOOZE.
  - Any state, `arm_en` = 0: go to OFF. This has the highest priority.
  - OFF, `arm_en` = 1: go to ARMED.
  - ARMED, `match_edge`: go to RING, ring_cnt = 0.
    - Arming while `match` is already true does not ring until the next edge, i.e. the next day.
  - RING, `stop_btn`: go to ARMED.
  - RING, `snooze_btn`: go to SNOOZE, snooze_cnt = `SNOOZE_MIN`.
  - RING, `minute_tick` when ring_cnt = `RING_MIN`-1: go to ARMED (auto-stop). Any other tick increments ring_cnt.
  - SNOOZE, `stop_btn`: go to ARMED.
  - SNOOZE, `minute_tick`: decrement snooze_cnt. When it was 1, go to RING with ring_cnt = 0.
  - SNOOZE, `snooze_btn`: ignored.
- Priority within a cycle: `arm_en` low > `stop_btn` > `snooze_btn` > `minute_tick`.
- `match_edge` is ignored in RING and SNOOZE. `match_q` still tracks every cycle.
- Counters are 4 bits wide. Values saturate and never wrap.

## Timing
- Time digits change at edge N:
  - `match_edge` is seen in cycle N;
  - `sound_en` is high from edge N+1.
- Outputs are Moore:
  - `sound_en` = (state == RING);
  - `snoozing` = (state == SNOOZE).
  - Both are registered and glitch-free.
- Button pulse at edge N: the state change is visible at edge N+1.
- `load_err` and the stored registers update at the edge after the `alarm_load` sample.
- Reset asserted mid-RING: `sound_en` drops immediately (asynchronously). After release the block is in OFF.
- Spurious `minute_tick` in the first cycle after reset is harmless: it has no effect in OFF.
- Day wrap 23:59 → 00:00 with alarm 00:00 rings normally.

## Structure
- Package `alarm_pkg` holds:
  - `alarm_state_t` enum {OFF, ARMED, RING, SNOOZE};
  - `bcd_time_t` packed struct of four 4-bit digits;
  - function `bcd_time_valid(bcd_time_t)`.
- Sub-module `alarm_minute_tick`: registers `minone_now` and outputs `minute_tick`. It is reused by the sound block.

## Test plan
- Reset, then load 07:30 with `arm_en` = 1. Time steps 07:29 → 07:30. Expected: `sound_en` = 1 one cycle after the step. It stays high through one tick and drops on the second tick (`RING_MIN` = 2).
- In RING, pulse `snooze_btn`. Expected: `snoozing` = 1. After 5 minute ticks `sound_en` = 1 again. Then pulse `stop_btn`: state returns to ARMED, `sound_en` = 0.
- Load 24:00, then 09:60. Expected: `load_err` pulses each time and the stored alarm is unchanged. Load 23:59: accepted, `load_err` = 0.
- In RING, pulse `stop_btn` and `snooze_btn` in the same cycle. Expected: ARMED, `snoozing` = 0. Drop `arm_en` during SNOOZE: OFF next cycle, no later ring.
- Raise `arm_en` while time = alarm = 12:00. Expected: no ring. Alarm 00:00, time 23:59 → 00:00: rings.
- Assert `rstn` low mid-RING. Expected: `sound_en` = 0 with no clock edge; alarm reads 00:00 after release.
